// File: rtl/norm_sq_accumulator_if.sv
// Handshake bundle for norm_sq_accumulator: element input stream and sum-of-squares
// output toward the square-root stage.
interface norm_sq_accumulator_if #(
    parameter int unsigned DATA_W = 16
);
    logic                     start;
    logic                     in_valid;
    logic signed [DATA_W-1:0] in_data;
    logic                     in_ready;
    logic                     out_valid;
    logic [31:0]              out_data;
    logic                     out_ready;
    logic                     ovf;

    modport master (
        output start, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, ovf
    );

    modport slave (
        input  start, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, ovf
    );
endinterface

// File: rtl/norm_sq_accumulator.sv
// Two-stage sum-of-squares over a VEC_LEN element vector (square, then accumulate).
// Define NORM_SQ_SAT_EN to saturate the accumulator on overflow instead of wrapping.
module norm_sq_accumulator #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned VEC_LEN = 8
) (
    input logic                   clk,
    input logic                   rst,
    norm_sq_accumulator_if.slave  bus
);
    localparam int unsigned ACC_W = 32;
    localparam int unsigned CntW  = $clog2(VEC_LEN + 1);

    typedef enum logic [1:0] {StIdle, StAccum, StDrain, StDone} state_e;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         count_q, count_d;
    logic [2*DATA_W-1:0]     sq_q, sq_d;
    logic                    sq_valid_q, sq_valid_d;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic                    ovf_q, ovf_d;

    logic                    in_ready;
    logic                    accept;
    logic                    last_elem;
    logic                    start_vec;
    logic signed [2*DATA_W-1:0] data_ext;
    logic signed [2*DATA_W-1:0] prod;
    logic [ACC_W:0]          sum;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.start) state_d = StAccum;
            StAccum: if (accept && last_elem) state_d = StDrain;
            StDrain: if (!sq_valid_q) state_d = StDone;
            StDone:  if (bus.out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready      = (state_q == StAccum);
        bus.in_ready  = in_ready;
        bus.out_valid = (state_q == StDone);
        bus.out_data  = acc_q;
        bus.ovf       = ovf_q;
    end

    // Datapath
    always_comb begin
        accept     = bus.in_valid && in_ready;
        last_elem  = (count_q == CntW'(VEC_LEN - 1));
        start_vec  = (state_q == StIdle) && bus.start;
        // Sign-extend before squaring so -2^(DATA_W-1) squares exactly.
        data_ext   = {{DATA_W{bus.in_data[DATA_W-1]}}, bus.in_data};
        prod       = data_ext * data_ext;
        sum        = {1'b0, acc_q} + (ACC_W + 1)'(sq_q);

        count_d    = count_q;
        sq_d       = sq_q;
        sq_valid_d = accept;
        acc_d      = acc_q;
        ovf_d      = ovf_q;

        if (accept) begin
            sq_d    = prod;
            count_d = count_q + 1'b1;
        end

        if (start_vec) begin
            count_d = '0;
            acc_d   = '0;
            ovf_d   = 1'b0;
        end else if (sq_valid_q) begin
            ovf_d = ovf_q | sum[ACC_W];
`ifdef NORM_SQ_SAT_EN
            acc_d = (ovf_q || sum[ACC_W]) ? '1 : sum[ACC_W-1:0];
`else
            acc_d = sum[ACC_W-1:0];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            sq_q       <= '0;
            sq_valid_q <= 1'b0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            count_q    <= count_d;
            sq_q       <= sq_d;
            sq_valid_q <= sq_valid_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
        end
    end
endmodule

// File: tb/tb_norm_sq_accumulator.sv
// Scoreboard bench for norm_sq_accumulator (VEC_LEN=4, DATA_W=16).
module tb_norm_sq_accumulator;
    localparam int unsigned DW = 16;
    localparam int unsigned VL = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    norm_sq_accumulator_if #(.DATA_W(DW)) bus ();

    norm_sq_accumulator #(
        .DATA_W  (DW),
        .VEC_LEN (VL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int unsigned cycle = 0;
    logic [32:0] exp_q[$];
    logic [31:0] m_acc;
    logic        m_ovf;

    always @(posedge clk) cycle <= cycle + 1;

    // in_ready and out_valid must never be high together
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            n_cmp++;
            if (bus.in_ready === 1'b1 && bus.out_valid === 1'b1) begin
                n_err++;
                $display("FAIL ready_valid_excl: in_ready=1 out_valid=1, required not both");
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_vector(output int unsigned t0);
        t0 = cycle;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        m_acc = '0;
        m_ovf = 1'b0;
    endtask

    task automatic model_add(input logic signed [15:0] v);
        logic signed [31:0] ve;
        logic [31:0]        sq;
        logic [32:0]        s;
        ve = v;
        sq = 32'(ve * ve);
        s  = {1'b0, m_acc} + {1'b0, sq};
        if (s[32]) m_ovf = 1'b1;
`ifdef NORM_SQ_SAT_EN
        m_acc = m_ovf ? 32'hFFFF_FFFF : s[31:0];
`else
        m_acc = s[31:0];
`endif
    endtask

    task automatic send_elem(input logic signed [15:0] v);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (bus.in_ready === 1'b1) ok = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        if (ok) model_add(v);
    endtask

    task automatic run_vec(input logic signed [15:0] a, input logic signed [15:0] b,
                           input logic signed [15:0] c, input logic signed [15:0] d,
                           input int gap, output int unsigned t0);
        start_vector(t0);
        send_elem(a); repeat (gap) tick();
        send_elem(b); repeat (gap) tick();
        send_elem(c); repeat (gap) tick();
        send_elem(d);
        exp_q.push_back({m_ovf, m_acc});
    endtask

    task automatic wait_out(output int unsigned seen, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (bus.out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        seen = cycle;
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
            n_err++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready);
        end
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
        end
        n_cmp++;
        if (bus.out_data !== 32'h0) begin
            n_err++; $display("FAIL reset_out_data: got %h want 0", bus.out_data);
        end
        n_cmp++;
        if (bus.ovf !== 1'b0) begin
            n_err++; $display("FAIL reset_ovf: got %b want 0", bus.ovf);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        int unsigned t0, seen;
        bit ok;
        logic [32:0] exp;
        run_vec(16'sd3, 16'sd4, 16'sd0, 16'sd0, 0, t0);
        wait_out(seen, ok);
        n_cmp++;
        if (!ok) begin
            n_err++; $display("FAIL b2b_timeout: out_valid=0 want 1");
        end else begin
            exp = exp_q.pop_front();
            n_cmp++;
            if (seen - t0 != 7) begin
                n_err++; $display("FAIL b2b_latency: got %0d cycles want 7", seen - t0);
            end
            n_cmp++;
            if ({bus.ovf, bus.out_data} !== exp || exp !== {1'b0, 32'd25}) begin
                n_err++;
                $display("FAIL b2b_data: got ovf=%b data=%0d want ovf=0 data=25",
                         bus.ovf, bus.out_data);
            end
        end
        consume();
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL b2b_release: out_valid=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_gaps();
        int unsigned t0, seen;
        bit ok;
        logic [32:0] exp;
        logic signed [15:0] vals [4];
        vals = '{-16'sd3, -16'sd4, 16'sd12, 16'sd0};
        start_vector(t0);
        for (int k = 0; k < 4; k++) begin
            send_elem(vals[k]);
            if (k < 3) begin
                for (int g = 0; g < 2; g++) begin
                    n_cmp++;
                    if (bus.in_ready !== 1'b1) begin
                        n_err++; $display("FAIL gap_in_ready: got %b want 1", bus.in_ready);
                    end
                    tick();
                end
            end
        end
        exp_q.push_back({m_ovf, m_acc});
        wait_out(seen, ok);
        n_cmp++;
        if (!ok) begin
            n_err++; $display("FAIL gap_timeout: out_valid=0 want 1");
        end else begin
            exp = exp_q.pop_front();
            n_cmp++;
            if ({bus.ovf, bus.out_data} !== exp || bus.out_data !== 32'd169) begin
                n_err++;
                $display("FAIL gap_data: got ovf=%b data=%0d want ovf=0 data=169",
                         bus.ovf, bus.out_data);
            end
        end
        consume();
    endtask

    task automatic test_overflow();
        int unsigned t0, seen;
        bit ok;
        logic [32:0] exp;
        run_vec(-16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768, 0, t0);
        wait_out(seen, ok);
        n_cmp++;
        if (!ok) begin
            n_err++; $display("FAIL ovf_timeout: out_valid=0 want 1");
        end else begin
            exp = exp_q.pop_front();
            n_cmp++;
            if ({bus.ovf, bus.out_data} !== exp) begin
                n_err++;
                $display("FAIL ovf_data: got ovf=%b data=%h want ovf=%b data=%h",
                         bus.ovf, bus.out_data, exp[32], exp[31:0]);
            end
            n_cmp++;
            if (bus.ovf !== 1'b1) begin
                n_err++; $display("FAIL ovf_flag: got %b want 1", bus.ovf);
            end
        end
        consume();
    endtask

    task automatic test_hold();
        int unsigned t0, seen;
        bit ok;
        logic [32:0] exp;
        run_vec(16'sd100, 16'sd200, 16'sd300, 16'sd400, 0, t0);
        wait_out(seen, ok);
        exp = exp_q.pop_front();
        n_cmp++;
        if (!ok) begin
            n_err++; $display("FAIL hold_timeout: out_valid=0 want 1");
        end
        for (int i = 0; i < 5; i++) begin
            bus.start = (i % 2 == 0);
            tick();
            n_cmp++;
            if (bus.out_valid !== 1'b1 || {bus.ovf, bus.out_data} !== exp
                || exp[31:0] !== 32'd300000) begin
                n_err++;
                $display("FAIL hold_stable: got valid=%b data=%0d want valid=1 data=300000",
                         bus.out_valid, bus.out_data);
            end
        end
        bus.start = 1'b0;
        consume();
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL hold_release: got valid=%b ready=%b want 0/0",
                     bus.out_valid, bus.in_ready);
        end
        tick();
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
            n_err++; $display("FAIL hold_start_ignored: in_ready=%b want 0", bus.in_ready);
        end
    endtask

    task automatic test_reset_mid();
        int unsigned t0, seen;
        bit ok, early;
        logic [32:0] exp;
        start_vector(t0);
        send_elem(16'sd5);
        send_elem(16'sd6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL abort_idle: got ready=%b valid=%b want 0/0",
                     bus.in_ready, bus.out_valid);
        end
        early = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (bus.out_valid === 1'b1) early = 1'b1;
            tick();
        end
        n_cmp++;
        if (early) begin
            n_err++; $display("FAIL abort_no_output: out_valid=1 want 0");
        end
        run_vec(16'sd1, 16'sd1, 16'sd1, 16'sd1, 0, t0);
        wait_out(seen, ok);
        n_cmp++;
        if (!ok) begin
            n_err++; $display("FAIL abort_timeout: out_valid=0 want 1");
        end else begin
            exp = exp_q.pop_front();
            n_cmp++;
            if ({bus.ovf, bus.out_data} !== exp || bus.out_data !== 32'd4) begin
                n_err++;
                $display("FAIL abort_data: got ovf=%b data=%0d want ovf=0 data=4",
                         bus.ovf, bus.out_data);
            end
        end
        consume();
    endtask

    task automatic test_start_with_ready();
        int unsigned t0, seen;
        bit ok;
        logic [32:0] exp;
        run_vec(16'sd7, 16'sd0, 16'sd0, 16'sd1, 1, t0);
        wait_out(seen, ok);
        exp = exp_q.pop_front();
        n_cmp++;
        if (!ok || {bus.ovf, bus.out_data} !== exp || bus.out_data !== 32'd50) begin
            n_err++;
            $display("FAIL swr_data: got valid=%b data=%0d want valid=1 data=50",
                     bus.out_valid, bus.out_data);
        end
        bus.start     = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL swr_idle: got valid=%b ready=%b want 0/0",
                     bus.out_valid, bus.in_ready);
        end
        tick();
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
            n_err++; $display("FAIL swr_start_ignored: in_ready=%b want 0", bus.in_ready);
        end
        run_vec(16'sd2, 16'sd2, 16'sd2, 16'sd2, 0, t0);
        wait_out(seen, ok);
        exp = exp_q.pop_front();
        n_cmp++;
        if (!ok || {bus.ovf, bus.out_data} !== exp || bus.out_data !== 32'd16) begin
            n_err++;
            $display("FAIL swr_next: got valid=%b data=%0d want valid=1 data=16",
                     bus.out_valid, bus.out_data);
        end
        consume();
    endtask

    task automatic test_random();
        int unsigned t0, seen;
        bit ok;
        logic [32:0] exp;
        for (int n = 0; n < 4; n++) begin
            run_vec(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                    16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                    int'($urandom_range(0, 2)), t0);
            wait_out(seen, ok);
            exp = exp_q.pop_front();
            n_cmp++;
            if (!ok || {bus.ovf, bus.out_data} !== exp) begin
                n_err++;
                $display("FAIL rand_vec%0d: got valid=%b ovf=%b data=%h want ovf=%b data=%h",
                         n, bus.out_valid, bus.ovf, bus.out_data, exp[32], exp[31:0]);
            end
            consume();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        m_acc         = '0;
        m_ovf         = 1'b0;
        test_reset();
        test_back_to_back();
        test_gaps();
        test_overflow();
        test_hold();
        test_reset_mid();
        test_start_with_ready();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
